tmds_serializer: RTL and testbench

TMDS_SERIALIZER -- requirements
Module: tmds_serializer

---
 rtl/tmds_serializer.sv | 109 ++++++++++
 tb/tb_tmds_serializer.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/tmds_serializer.sv
// TMDS lane serializer: one holding register feeding per-lane shift
// registers, with idle substitution, underflow counting and a clock lane.
module tmds_serializer #(
  parameter int NCH = 3,
  parameter int WORD_W = 10,
  parameter int BITS = 2,
  parameter logic [NCH:0] INV_MASK = '1,
  parameter logic [WORD_W-1:0] IDLE_WORD = 10'b1101010100,
  parameter logic [WORD_W-1:0] CLK_PATTERN =
    {{(WORD_W/2){1'b0}}, {(WORD_W/2){1'b1}}}
) (
  input  logic                       clk,
  input  logic                       nreset,
  input  logic [NCH*WORD_W-1:0]      in_data,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic [BITS*(NCH+1)-1:0]    dout,
  output logic                       word_strobe,
  output logic                       underflow,
  output logic [15:0]                underflow_cnt
);

  localparam int P  = WORD_W / BITS;
  localparam int PW = (P > 1) ? $clog2(P) : 1;

  logic [PW-1:0]               phase_q, phase_d;
  logic [NCH:0][WORD_W-1:0]    shift_q, shift_d;
  logic [NCH*WORD_W-1:0]       hold_q, hold_d;
  logic                        hold_valid_q, hold_valid_d;
  logic                        strobe_q, strobe_d;
  logic                        uf_q, uf_d;
  logic [15:0]                 cnt_q, cnt_d;
  logic                        boundary;
  logic                        xfer;

  // Boundary detection and input handshake.
  always_comb begin
    boundary = (phase_q == PW'(P - 1));
    in_ready = !hold_valid_q || boundary;
    xfer     = in_valid && in_ready;
  end

  // Next-state: phase, lane loads/shifts, holding register, status.
  always_comb begin
    phase_d      = boundary ? '0 : phase_q + PW'(1);
    shift_d      = shift_q;
    hold_d       = hold_q;
    hold_valid_d = hold_valid_q;
    strobe_d     = boundary;
    uf_d         = boundary && !hold_valid_q;
    cnt_d        = cnt_q;
    for (int k = 0; k <= NCH; k++) begin
      if (boundary) begin
        if (k == NCH) begin
          shift_d[k] = CLK_PATTERN;
        end else if (hold_valid_q) begin
          shift_d[k] = hold_q[k*WORD_W +: WORD_W];
        end else begin
          shift_d[k] = IDLE_WORD;
        end
      end else begin
        shift_d[k] = shift_q[k] >> BITS;
      end
    end
    if (xfer) begin
      hold_d       = in_data;
      hold_valid_d = 1'b1;
    end else if (boundary) begin
      hold_valid_d = 1'b0;
    end
    if (uf_d && cnt_q != 16'hFFFF) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  // State registers; reset parks the phase just before a boundary.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      phase_q      <= PW'(P - 1);
      shift_q      <= '0;
      hold_q       <= '0;
      hold_valid_q <= 1'b0;
      strobe_q     <= 1'b0;
      uf_q         <= 1'b0;
      cnt_q        <= '0;
    end else begin
      phase_q      <= phase_d;
      shift_q      <= shift_d;
      hold_q       <= hold_d;
      hold_valid_q <= hold_valid_d;
      strobe_q     <= strobe_d;
      uf_q         <= uf_d;
      cnt_q        <= cnt_d;
    end
  end

  // Serial outputs come straight from the lane registers' low bits.
  always_comb begin
    dout = '0;
    for (int k = 0; k <= NCH; k++) begin
      dout[k*BITS +: BITS] = shift_q[k][BITS-1:0] ^ {BITS{INV_MASK[k]}};
    end
  end

  assign word_strobe   = strobe_q;
  assign underflow     = uf_q;
  assign underflow_cnt = cnt_q;

endmodule

// File: tb/tb_tmds_serializer.sv
// Randomized self-checking bench for tmds_serializer with a
// word-level reference model, plus saturation and SDR instances.
module tb_tmds_serializer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Main instance: defaults
  logic        nrst_a = 1'b0;
  logic [29:0] din_a = '0;
  logic        vld_a = 1'b0;
  logic        rdy_a;
  logic [7:0]  dout_a;
  logic        stb_a, uf_a;
  logic [15:0] cnt_a;

  tmds_serializer dut_a (
    .clk(clk), .nreset(nrst_a), .in_data(din_a), .in_valid(vld_a),
    .in_ready(rdy_a), .dout(dout_a), .word_strobe(stb_a),
    .underflow(uf_a), .underflow_cnt(cnt_a)
  );

  // Saturation instance: one-cycle words, so every cycle underflows
  logic        nrst_b = 1'b0;
  logic [1:0]  din_b = '0;
  logic        vld_b = 1'b0;
  logic        rdy_b;
  logic [3:0]  dout_b;
  logic        stb_b, uf_b;
  logic [15:0] cnt_b;

  tmds_serializer #(
    .NCH(1), .WORD_W(2), .BITS(2), .INV_MASK(2'b00),
    .IDLE_WORD(2'b01), .CLK_PATTERN(2'b01)
  ) dut_b (
    .clk(clk), .nreset(nrst_b), .in_data(din_b), .in_valid(vld_b),
    .in_ready(rdy_b), .dout(dout_b), .word_strobe(stb_b),
    .underflow(uf_b), .underflow_cnt(cnt_b)
  );

  // SDR instance
  logic        nrst_c = 1'b0;
  logic [9:0]  din_c = '0;
  logic        vld_c = 1'b0;
  logic        rdy_c;
  logic [1:0]  dout_c;
  logic        stb_c, uf_c;
  logic [15:0] cnt_c;

  tmds_serializer #(
    .NCH(1), .WORD_W(10), .BITS(1), .INV_MASK(2'b00)
  ) dut_c (
    .clk(clk), .nreset(nrst_c), .in_data(din_c), .in_valid(vld_c),
    .in_ready(rdy_c), .dout(dout_c), .word_strobe(stb_c),
    .underflow(uf_c), .underflow_cnt(cnt_c)
  );

  // Reference model for the main instance (word level)
  localparam int P = 5;
  localparam logic [9:0] IDLE = 10'b1101010100;
  localparam logic [9:0] CLKP = 10'b0000011111;
  logic [3:0] inv = 4'hF;

  int         m_t;
  int         m_j;
  bit         m_hv;
  logic [29:0] m_hold;
  logic [9:0] m_cur [4];
  bit         m_stb, m_uf;
  int         m_cnt;

  task automatic m_reset();
    m_t = 0; m_j = 0; m_hv = 0; m_hold = '0;
    for (int k = 0; k < 4; k++) m_cur[k] = '0;
    m_stb = 0; m_uf = 0; m_cnt = 0;
  endtask

  function automatic logic [7:0] m_dout();
    logic [7:0] e;
    logic [9:0] s;
    e = '0;
    for (int k = 0; k < 4; k++) begin
      s = m_cur[k] >> (2 * m_j);
      e[k*2 +: 2] = s[1:0] ^ {2{inv[k]}};
    end
    return e;
  endfunction

  task automatic m_check(input string tag);
    chk({tag, ".dout"}, 32'(dout_a), 32'(m_dout()));
    chk({tag, ".stb"}, 32'(stb_a), 32'(m_stb));
    chk({tag, ".uf"}, 32'(uf_a), 32'(m_uf));
    chk({tag, ".cnt"}, 32'(cnt_a), 32'(m_cnt));
  endtask

  // One clock of the main instance, entered and left at posedge+1.
  task automatic cyc(input bit v, input logic [29:0] d, input string tag);
    bit bnd, rdy, x;
    vld_a = v;
    din_a = d;
    #1;
    bnd = (m_t % P == 0);
    rdy = !m_hv || bnd;
    x   = v && rdy;
    chk({tag, ".rdy"}, 32'(rdy_a), 32'(rdy));
    @(posedge clk);
    #1;
    if (bnd) begin
      for (int k = 0; k < 3; k++)
        m_cur[k] = m_hv ? m_hold[k*10 +: 10] : IDLE;
      m_cur[3] = CLKP;
      m_j = 0;
      m_stb = 1;
      m_uf = !m_hv;
      if (!m_hv && m_cnt < 65535) m_cnt++;
      m_hv = x;
    end else begin
      m_j++;
      m_stb = 0;
      m_uf = 0;
      if (x) m_hv = 1;
    end
    if (x) m_hold = d;
    m_t++;
    m_check(tag);
  endtask

  task automatic run_main();
    int guard;
    #12;
    chk("rst.dout", 32'(dout_a), 32'h0000_00FF);
    chk("rst.rdy", 32'(rdy_a), 32'd1);
    chk("rst.stb", 32'(stb_a), 32'd0);
    chk("rst.uf", 32'(uf_a), 32'd0);
    chk("rst.cnt", 32'(cnt_a), 32'd0);
    @(posedge clk); #1;
    nrst_a = 1'b1;
    m_reset();
    // Idle after release
    for (int i = 0; i < 12; i++) cyc(0, '0, "idle");
    // Random valid/data
    for (int i = 0; i < 80; i++)
      cyc(bit'($urandom_range(0, 1)), 30'($urandom), "rnd");
    // Continuous stream of fixed words
    for (int i = 0; i < 25; i++)
      cyc(1, {10'h155, 10'h000, 10'h3FF}, "full");
    // Drain, then first valid exactly on a boundary
    for (int i = 0; i < 12; i++) cyc(0, '0, "drain");
    guard = 0;
    while (m_t % P != 0 && guard < 10) begin
      cyc(0, '0, "align");
      guard++;
    end
    cyc(1, 30'h2AB_CDEF, "bnd1st");
    for (int i = 0; i < 12; i++) cyc(0, '0, "bnd1st");
    // Mid-word reset with a held word pending
    guard = 0;
    while (!(m_hv && m_t % P == 3) && guard < 20) begin
      cyc(1, 30'h0F0_F0F0, "prerst");
      guard++;
    end
    chk("prerst.reach", 32'(guard < 20), 32'd1);
    nrst_a = 1'b0;
    vld_a = 1'b0;
    #1;
    chk("mrst.dout", 32'(dout_a), 32'h0000_00FF);
    chk("mrst.rdy", 32'(rdy_a), 32'd1);
    chk("mrst.stb", 32'(stb_a), 32'd0);
    chk("mrst.uf", 32'(uf_a), 32'd0);
    chk("mrst.cnt", 32'(cnt_a), 32'd0);
    @(posedge clk); @(posedge clk); #1;
    nrst_a = 1'b1;
    m_reset();
    for (int i = 0; i < 12; i++) cyc(0, '0, "postrst");
    for (int i = 0; i < 150; i++)
      cyc(bit'($urandom_range(0, 3) != 0), 30'($urandom), "rnd2");
  endtask

  task automatic run_sat();
    @(posedge clk); #1;
    nrst_b = 1'b1;
    repeat (65534) @(posedge clk);
    #1;
    chk("sat.fffe", 32'(cnt_b), 32'h0000_FFFE);
    chk("sat.uf", 32'(uf_b), 32'd1);
    chk("sat.dout", 32'(dout_b), 32'h0000_0005);
    @(posedge clk); #1;
    chk("sat.ffff", 32'(cnt_b), 32'h0000_FFFF);
    repeat (5) @(posedge clk);
    #1;
    chk("sat.hold", 32'(cnt_b), 32'h0000_FFFF);
  endtask

  task automatic run_sdr();
    logic [9:0] exp_bits [10];
    exp_bits = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 1};
    @(posedge clk); #1;
    nrst_c = 1'b1;
    vld_c = 1'b1;
    din_c = 10'b1000000001;
    repeat (11) @(posedge clk);
    #1;
    for (int j = 0; j < 10; j++) begin
      chk($sformatf("sdr.d%0d", j), 32'(dout_c[0]), 32'(exp_bits[j][0]));
      chk($sformatf("sdr.c%0d", j), 32'(dout_c[1]), 32'(CLKP[j]));
      chk($sformatf("sdr.s%0d", j), 32'(stb_c), 32'(j == 0));
      @(posedge clk); #1;
    end
    chk("sdr.wrap", 32'(stb_c), 32'd1);
    chk("sdr.uf", 32'(cnt_c), 32'd1);
  endtask

  initial begin
    fork
      run_main();
      run_sat();
      run_sdr();
    join
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
